// File: rtl/processing_element_if.sv
// rtl/processing_element_if.sv - descriptor/window/partial-sum bundle for one systolic matching cell
interface processing_element_if #(
    parameter int DW = 33,
    parameter int AW = 8
);
    logic [DW-1:0] descIn;
    logic [DW-1:0] windowIn;
    logic          loadDesc;
    logic          loadWin;
    logic          loadAcc;
    logic [AW-1:0] accIn;
    logic [AW-1:0] accOut;
    logic [DW-1:0] windowOut;

    modport master (
        output descIn, windowIn, loadDesc, loadWin, loadAcc, accIn,
        input  accOut, windowOut
    );

    modport slave (
        input  descIn, windowIn, loadDesc, loadWin, loadAcc, accIn,
        output accOut, windowOut
    );
endinterface

// File: rtl/processing_element.sv
// rtl/processing_element.sv - systolic cell: log2|desc-win| added to upstream partial sum
// Optional macro PE_ACC_SAT_EN: saturate the partial sum instead of wrapping.
module processing_element #(
    parameter int DW = 33,
    parameter int AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    processing_element_if.slave   pe_if
);
    logic [DW-1:0] desc_q, desc_d;
    logic [DW-1:0] win_q,  win_d;
    logic [AW-1:0] acc_q,  acc_d;

    logic signed [DW:0] diff;
    logic [DW:0]        tempSum;
    logic [AW-1:0]      tempSumLog2;
    logic [AW:0]        acc_wide;
    logic [AW-1:0]      accSum;

    // Sign-extend one bit so the difference of two extreme Q6.27 values cannot overflow.
    assign diff    = $signed({desc_q[DW-1], desc_q}) - $signed({win_q[DW-1], win_q});
    assign tempSum = diff[DW] ? (~diff + 1'b1) : diff;

    always_comb begin
        tempSumLog2 = '0;
        for (int i = 0; i <= DW; i++) begin
            if (tempSum[i]) begin
                tempSumLog2 = AW'(i + 1);
            end
        end
    end

    assign acc_wide = {1'b0, pe_if.accIn} + {1'b0, tempSumLog2};

`ifdef PE_ACC_SAT_EN
    assign accSum = acc_wide[AW] ? {AW{1'b1}} : acc_wide[AW-1:0];
`else
    assign accSum = acc_wide[AW-1:0];
`endif

    always_comb begin
        desc_d = desc_q;
        win_d  = win_q;
        acc_d  = acc_q;
        if (pe_if.loadDesc) desc_d = pe_if.descIn;
        if (pe_if.loadWin)  win_d  = pe_if.windowIn;
        if (pe_if.loadAcc)  acc_d  = accSum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            desc_q <= '0;
            win_q  <= '0;
            acc_q  <= '0;
        end else begin
            desc_q <= desc_d;
            win_q  <= win_d;
            acc_q  <= acc_d;
        end
    end

    assign pe_if.windowOut = win_q;
    assign pe_if.accOut    = acc_q;
endmodule

// File: tb/tb_processing_element.sv
// tb/tb_processing_element.sv - directed self-checking bench on a four-cell window chain
module tb_processing_element;
    localparam int DW = 33;
    localparam int AW = 8;

    localparam logic [DW-1:0] ONE     = 33'h0_0800_0000;
    localparam logic [DW-1:0] TWO     = 33'h0_1000_0000;
    localparam logic [DW-1:0] FOUR    = 33'h0_2000_0000;
    localparam logic [DW-1:0] EIGHT   = 33'h0_4000_0000;
    localparam logic [DW-1:0] SIXTEEN = 33'h0_8000_0000;
    localparam logic [DW-1:0] NEG_ONE = 33'h1_F800_0000;

    logic clk = 1'b0;
    logic rst;
    logic load_desc, load_win, load_acc;
    logic [DW-1:0] win_in;
    logic [DW-1:0] desc_in [4];
    logic [AW-1:0] acc_in  [4];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    processing_element_if #(.DW(DW), .AW(AW)) pif0 ();
    processing_element_if #(.DW(DW), .AW(AW)) pif1 ();
    processing_element_if #(.DW(DW), .AW(AW)) pif2 ();
    processing_element_if #(.DW(DW), .AW(AW)) pif3 ();

    assign pif0.descIn = desc_in[0];
    assign pif1.descIn = desc_in[1];
    assign pif2.descIn = desc_in[2];
    assign pif3.descIn = desc_in[3];
    assign pif0.accIn  = acc_in[0];
    assign pif1.accIn  = acc_in[1];
    assign pif2.accIn  = acc_in[2];
    assign pif3.accIn  = acc_in[3];
    assign pif0.windowIn = win_in;
    assign pif1.windowIn = pif0.windowOut;
    assign pif2.windowIn = pif1.windowOut;
    assign pif3.windowIn = pif2.windowOut;
    assign pif0.loadDesc = load_desc;
    assign pif1.loadDesc = load_desc;
    assign pif2.loadDesc = load_desc;
    assign pif3.loadDesc = load_desc;
    assign pif0.loadWin  = load_win;
    assign pif1.loadWin  = load_win;
    assign pif2.loadWin  = load_win;
    assign pif3.loadWin  = load_win;
    assign pif0.loadAcc  = load_acc;
    assign pif1.loadAcc  = load_acc;
    assign pif2.loadAcc  = load_acc;
    assign pif3.loadAcc  = load_acc;

    processing_element #(.DW(DW), .AW(AW)) u_pe0 (.clk(clk), .rst(rst), .pe_if(pif0));
    processing_element #(.DW(DW), .AW(AW)) u_pe1 (.clk(clk), .rst(rst), .pe_if(pif1));
    processing_element #(.DW(DW), .AW(AW)) u_pe2 (.clk(clk), .rst(rst), .pe_if(pif2));
    processing_element #(.DW(DW), .AW(AW)) u_pe3 (.clk(clk), .rst(rst), .pe_if(pif3));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] wrap_exp;
        // Reset wins over every strobe, even with non-zero data on all inputs.
        rst = 1'b1; load_desc = 1'b1; load_win = 1'b1; load_acc = 1'b1;
        win_in = SIXTEEN;
        for (int k = 0; k < 4; k++) begin
            desc_in[k] = EIGHT;
            acc_in[k]  = 8'd99;
        end
        tick();
        rst = 1'b0; load_desc = 1'b0; load_win = 1'b0; load_acc = 1'b0;
        for (int k = 0; k < 4; k++) acc_in[k] = '0;
        check("rst_win0", pif0.windowOut, 0);
        check("rst_win1", pif1.windowOut, 0);
        check("rst_win2", pif2.windowOut, 0);
        check("rst_win3", pif3.windowOut, 0);
        check("rst_acc0", pif0.accOut, 0);
        check("rst_acc1", pif1.accOut, 0);
        check("rst_acc2", pif2.accOut, 0);
        check("rst_acc3", pif3.accOut, 0);
        check("rst_desc0", u_pe0.desc_q, 0);

        desc_in[0] = ONE; desc_in[1] = TWO; desc_in[2] = FOUR; desc_in[3] = EIGHT;
        load_desc = 1'b1;
        tick();
        load_desc = 1'b0;
        load_win = 1'b1;
        tick();
        load_win = 1'b0;
        check("shift1_win0", pif0.windowOut, SIXTEEN);
        check("code_cell0", u_pe0.tempSumLog2, 31);
        check("code_cell1", u_pe1.tempSumLog2, 29);
        check("code_cell2", u_pe2.tempSumLog2, 30);
        check("code_cell3", u_pe3.tempSumLog2, 31);
        check("shift1_win1", pif1.windowOut, 0);

        load_win = 1'b1;
        tick();
        check("shift2_win1", pif1.windowOut, SIXTEEN);
        check("shift2_win2", pif2.windowOut, 0);
        tick();
        check("shift3_win2", pif2.windowOut, SIXTEEN);
        check("shift3_win3", pif3.windowOut, 0);
        tick();
        check("shift4_win3", pif3.windowOut, SIXTEEN);
        load_win = 1'b0;

        // Equal operands give code 0, so the partial sum passes straight through.
        desc_in[0] = SIXTEEN;
        load_desc = 1'b1;
        tick();
        load_desc = 1'b0;
        check("equal_code", u_pe0.tempSumLog2, 0);
        acc_in[0] = 8'd7;
        load_acc = 1'b1;
        tick();
        load_acc = 1'b0;
        check("equal_acc", pif0.accOut, 7);
        acc_in[0] = 8'd100;
        tick();
        check("hold_acc", pif0.accOut, 7);

        desc_in[0] = NEG_ONE;
        win_in = ONE;
        load_desc = 1'b1; load_win = 1'b1;
        tick();
        load_desc = 1'b0; load_win = 1'b0;
        check("signed_code", u_pe0.tempSumLog2, 29);
        acc_in[0] = 8'd0;
        load_acc = 1'b1;
        tick();
        load_acc = 1'b0;
        check("signed_acc", pif0.accOut, 29);

        acc_in[0] = 8'd250;
        load_acc = 1'b1;
        tick();
        load_acc = 1'b0;
`ifdef PE_ACC_SAT_EN
        wrap_exp = 8'd255;
`else
        wrap_exp = 8'd23;
`endif
        check("overflow_acc", pif0.accOut, wrap_exp);

        // Same-edge window load and accumulate: the accumulator sees the old window.
        win_in = NEG_ONE;
        acc_in[0] = 8'd0;
        load_win = 1'b1; load_acc = 1'b1;
        tick();
        load_win = 1'b0;
        check("sameedge_acc", pif0.accOut, 29);
        tick();
        load_acc = 1'b0;
        check("after_sameedge_acc", pif0.accOut, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
